// File: rtl/demux_router.sv
// ---------------------------------------------------------------------------
// demux_router
//
// Registered 1-to-CH demultiplexer. One input word stream is steered by
// in_sel into one of CH single-entry output registers. Each output channel
// has its own valid/ready handshake, so a stalled consumer only blocks words
// aimed at its own channel.
//
// Parameters
//   WIDTH  data word width in bits (>= 1)
//   CH     number of output channels (2..256); need not be a power of two
//   SEL_W  select width, derived as $clog2(CH)
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_data    word to be routed
//   in_sel     destination channel index
//   in_valid   in_data/in_sel valid this cycle
//   in_ready   router accepts the word this cycle (combinational)
//   mode       0 = hold (idle channel keeps last word), 1 = clear (idle -> 0)
//   out_data   channel k occupies bits [k*WIDTH +: WIDTH], registered
//   out_valid  per-channel word-present flag, registered
//   out_ready  per-channel consumer ready
//   err_cnt    saturating count of words dropped for in_sel >= CH
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holding valid high must
// keep its payload stable until that edge; valid never drops without a
// transfer except through reset. in_ready never depends on in_valid.
// ---------------------------------------------------------------------------
module demux_router #(
    parameter  int WIDTH = 8,
    parameter  int CH    = 8,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    output logic [CH*WIDTH-1:0] out_data,
    output logic [CH-1:0]       out_valid,
    input  logic [CH-1:0]       out_ready,
    output logic [7:0]          err_cnt
);

    // Per-channel single-entry storage.
    logic [WIDTH-1:0] data_q [CH];
    logic [CH-1:0]    valid_q;
    logic [7:0]       err_q;

    // One-hot decode of in_sel. An out-of-range select decodes to all zeros,
    // which is how in_range is derived; this also keeps every index into the
    // per-channel vectors inside 0..CH-1.
    logic [CH-1:0] sel_hit;
    logic          in_range;
    logic          slot_free;
    logic          accept;
    logic [CH-1:0] load;
    logic [CH-1:0] drain;

    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < CH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_hit[k] = 1'b1;
            end
        end
    end

    assign in_range = |sel_hit;

    // The addressed slot can take a word if it is empty or is being drained
    // on this same edge (full-throughput refill).
    assign slot_free = |(sel_hit & (~valid_q | out_ready));

    // Out-of-range words are always taken so they can be counted and
    // dropped; they never stall the stream.
    assign in_ready = in_range ? slot_free : 1'b1;

    assign accept = in_valid & in_ready;
    assign load   = sel_hit & {CH{accept}};
    assign drain  = valid_q & out_ready;

    // Channel registers. Load wins over drain, so a simultaneous drain and
    // refill keeps valid high and takes the new word. In clear mode a
    // drained channel with no refill is zeroed; words still waiting for
    // their consumer are never touched by mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < CH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (load[k]) begin
                    data_q[k]  <= in_data;
                    valid_q[k] <= 1'b1;
                end else if (drain[k]) begin
                    valid_q[k] <= 1'b0;
                    if (mode) begin
                        data_q[k] <= '0;
                    end
                end
            end
        end
    end

    // Dropped-word counter, saturating at 255. With a power-of-two CH the
    // decode always hits, so this never moves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 8'd0;
        end else if (accept && !in_range && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    // Flatten channel registers onto the output bus.
    for (genvar g = 0; g < CH; g++) begin : g_out
        assign out_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign out_valid = valid_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_demux_router.sv
// ---------------------------------------------------------------------------
// tb_demux_router
//
// Bench for demux_router with WIDTH=8, CH=6 (non power of two, so selects
// 6 and 7 are out of range). The driver issues one stimulus cycle at a time;
// every word it expects the router to take is pushed onto exp_q tagged with
// the clock edge at which it lands. The negedge monitor treats the oldest
// landed entry per channel as the channel's contents, compares it against
// out_valid/out_data, and pops it on a consumer handshake.
// ---------------------------------------------------------------------------
module tb_demux_router;

    localparam int WIDTH = 8;
    localparam int CH    = 6;
    localparam int SEL_W = $clog2(CH);
    localparam logic [CH-1:0] ALL = '1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [WIDTH-1:0]    in_data;
    logic [SEL_W-1:0]    in_sel;
    logic                in_valid;
    logic                in_ready;
    logic                mode;
    logic [CH*WIDTH-1:0] out_data;
    logic [CH-1:0]       out_valid;
    logic [CH-1:0]       out_ready;
    logic [7:0]          err_cnt;

    demux_router #(.WIDTH(WIDTH), .CH(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt)
    );

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [31:0]      edge_n;
        logic [7:0]       ch;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             exp_q[$];
    int               err_q[$];
    logic [WIDTH-1:0] idle_data [CH];
    int               cyc = 0;
    int               vectors = 0;
    int               miscompares = 0;
    bit               chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Oldest word for channel ch that has already landed in the DUT.
    function automatic int find_live(int ch);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (int'(exp_q[i].ch) == ch && int'(exp_q[i].edge_n) <= cyc) return i;
        end
        return -1;
    endfunction

    // A word for channel ch lands on the coming edge.
    function automatic bit pending_for(int ch);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (int'(exp_q[i].ch) == ch && int'(exp_q[i].edge_n) == cyc + 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int exp_err();
        int n;
        n = 0;
        foreach (err_q[i]) if (err_q[i] <= cyc) n++;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        err_q.delete();
        for (int k = 0; k < CH; k++) idle_data[k] = '0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < CH; k++) begin
                int               idx;
                logic [WIDTH-1:0] got;
                idx = find_live(k);
                got = out_data[k*WIDTH +: WIDTH];
                vectors++;
                if (out_valid[k] !== (idx >= 0)) begin
                    miscompares++;
                    $display("FAIL out_valid[%0d] cyc %0d: got %b expected %b", k, cyc, out_valid[k], (idx >= 0));
                end
                vectors++;
                if (idx >= 0) begin
                    if (got !== exp_q[idx].data) begin
                        miscompares++;
                        $display("FAIL out_data[%0d] cyc %0d: got %h expected %h", k, cyc, got, exp_q[idx].data);
                    end
                    if (out_ready[k] === 1'b1) begin
                        if (!pending_for(k)) idle_data[k] = mode ? '0 : exp_q[idx].data;
                        exp_q.delete(idx);
                    end
                end else begin
                    if (got !== idle_data[k]) begin
                        miscompares++;
                        $display("FAIL idle_data[%0d] cyc %0d: got %h expected %h", k, cyc, got, idle_data[k]);
                    end
                end
            end
            vectors++;
            if (int'(err_cnt) != exp_err()) begin
                miscompares++;
                $display("FAIL err_cnt cyc %0d: got %0d expected %0d", cyc, err_cnt, exp_err());
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; drives one cycle of inputs, checks
    // in_ready against the model, records the expected effect, and returns
    // just after the next rising edge.
    task automatic cycle(input logic v, input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] d,
                         input logic [CH-1:0] ordy, input logic md, output bit acc);
        bit   exp_rdy;
        int   sel_i;
        exp_t e;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        mode      = md;
        #1;
        sel_i = int'(s);
        if (sel_i >= CH) exp_rdy = 1'b1;
        else             exp_rdy = (find_live(sel_i) < 0) || (ordy[sel_i] == 1'b1);
        vectors++;
        if (in_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL in_ready cyc %0d sel %0d: got %b expected %b", cyc, sel_i, in_ready, exp_rdy);
        end
        acc = v && exp_rdy;
        if (acc && rst_n) begin
            if (sel_i < CH) begin
                e.edge_n = 32'(cyc + 1);
                e.ch     = 8'(sel_i);
                e.data   = d;
                exp_q.push_back(e);
            end else begin
                err_q.push_back(cyc + 1);
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) clear_model();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit               a;
        bit               hold;
        logic             v;
        logic             md;
        logic [SEL_W-1:0] hs;
        logic [WIDTH-1:0] hd;
        logic [CH-1:0]    ordy;
        logic [CH-1:0]    no5;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        mode      = 1'b0;
        @(posedge clk);
        #1;
        clear_model();
        chk_en = 1'b1;

        // Reset held with an acceptable word offered: in_ready follows the
        // formula but nothing is loaded.
        cycle(1'b1, 3'd2, 8'h5A, '0, 1'b0, a);
        rst_n = 1'b1;

        // Route 0xA5 to channel 3, drain, check hold-mode data.
        cycle(1'b1, 3'd3, 8'hA5, ALL, 1'b0, a);
        cycle(1'b0, 3'd0, 8'h00, ALL, 1'b0, a);
        cycle(1'b0, 3'd0, 8'h00, ALL, 1'b0, a);

        // Back-pressure on channel 5.
        no5 = ALL;
        no5[5] = 1'b0;
        cycle(1'b1, 3'd5, 8'h11, no5, 1'b0, a);
        cycle(1'b1, 3'd5, 8'h22, no5, 1'b0, a);
        cycle(1'b1, 3'd5, 8'h22, no5, 1'b0, a);
        cycle(1'b1, 3'd5, 8'h22, ALL, 1'b0, a);
        cycle(1'b0, 3'd0, 8'h00, ALL, 1'b0, a);

        // Streaming into channel 2.
        for (int i = 0; i < 10; i++) cycle(1'b1, 3'd2, WIDTH'(8'h30 + i), ALL, 1'b0, a);
        cycle(1'b0, 3'd0, 8'h00, ALL, 1'b0, a);

        // Clear mode: load 0x7E into channel 0, then drain with no refill.
        cycle(1'b1, 3'd0, 8'h7E, '0, 1'b1, a);
        cycle(1'b0, 3'd0, 8'h00, '0, 1'b1, a);
        cycle(1'b0, 3'd0, 8'h00, ALL, 1'b1, a);
        cycle(1'b0, 3'd0, 8'h00, ALL, 1'b0, a);

        // Reset mid-stream with channels 1 and 4 occupied.
        cycle(1'b1, 3'd1, 8'hC1, '0, 1'b0, a);
        cycle(1'b1, 3'd4, 8'hC4, '0, 1'b0, a);
        cycle(1'b0, 3'd0, 8'h00, '0, 1'b0, a);
        rst_n = 1'b0;
        cycle(1'b0, 3'd0, 8'h00, '0, 1'b0, a);
        rst_n = 1'b1;
        cycle(1'b1, 3'd4, 8'h44, ALL, 1'b0, a);
        cycle(1'b0, 3'd0, 8'h00, ALL, 1'b0, a);

        // Out-of-range flood: 300 words to sel 7, saturating err_cnt.
        for (int i = 0; i < 300; i++) cycle(1'b1, 3'd7, WIDTH'($urandom), CH'($urandom), 1'b0, a);
        cycle(1'b0, 3'd0, 8'h00, ALL, 1'b0, a);

        // Randomised traffic with occasional reset; the source holds a
        // refused word until it is taken.
        hold = 1'b0;
        hs   = '0;
        hd   = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!hold) begin
                v  = ($urandom_range(0, 3) != 0);
                hs = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
                hd = WIDTH'($urandom);
            end else begin
                v = 1'b1;
            end
            ordy  = CH'($urandom);
            md    = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 199) != 0);
            cycle(v, hs, hd, ordy, md, a);
            hold  = v && !a;
        end
        rst_n = 1'b1;
        cycle(1'b0, 3'd0, 8'h00, ALL, 1'b0, a);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
